// File: rtl/cache_pkg.sv
// Shared types and constants for the cache valid-bit flush sequencer.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } flush_state_t;

    // Word written to every entry during a sweep; sliced to the memory width at use.
    localparam logic [63:0] CACHE_INVALID = 64'd0;

endpackage

// File: rtl/cache_flush_walker.sv
// Sweep index counter: load-zero, increment, and all-ones terminal flag.
module cache_flush_walker #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + ADDR_WIDTH'(1);
        end
    end

    // Terminal on all-ones so the counter never needs an extra wrap bit.
    assign last = &idx;

endmodule

// File: rtl/cache_flush_ctrl.sv
// Flush sequencer and port arbiter for cache_vmem; CACHE_FLUSH_ON_RESET_EN
// makes reset start a full sweep instead of entering IDLE.
module cache_flush_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_write,
    input  logic [DATA_WIDTH-1:0] cache_data,
    output logic [ADDR_WIDTH-1:0] vmem_addr,
    output logic                  vmem_write,
    output logic [DATA_WIDTH-1:0] vmem_data,
    output logic                  cache_stall,
    output logic                  flush_done
);

`ifdef CACHE_FLUSH_ON_RESET_EN
    localparam flush_state_t RESET_STATE = FLUSH;
`else
    localparam flush_state_t RESET_STATE = IDLE;
`endif

    flush_state_t          state_q;
    flush_state_t          state_d;
    logic                  walk_clr;
    logic                  walk_inc;
    logic                  walk_last;
    logic [ADDR_WIDTH-1:0] idx;

    cache_flush_walker #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_walker (
        .clk  (clk),
        .rst  (rst),
        .clr  (walk_clr),
        .inc  (walk_inc),
        .idx  (idx),
        .last (walk_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        walk_clr    = 1'b0;
        walk_inc    = 1'b0;
        vmem_addr   = cache_addr;
        vmem_write  = cache_write;
        vmem_data   = cache_data;
        cache_stall = 1'b0;
        flush_done  = 1'b0;
        case (state_q)
            IDLE: begin
                // A fill in this same cycle still lands; the sweep then clears it.
                if (flush_req) begin
                    state_d  = FLUSH;
                    walk_clr = 1'b1;
                end
            end
            FLUSH: begin
                vmem_addr   = idx;
                vmem_write  = 1'b1;
                vmem_data   = CACHE_INVALID[DATA_WIDTH-1:0];
                cache_stall = 1'b1;
                if (walk_last) begin
                    state_d = DONE;
                end else begin
                    walk_inc = 1'b1;
                end
            end
            DONE: begin
                flush_done  = 1'b1;
                cache_stall = 1'b1;
                vmem_write  = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl with ADDR_WIDTH=3 and a behavioural cache_vmem.
module tb_cache_flush_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          flush_req;
    logic [AW-1:0] cache_addr;
    logic          cache_write;
    logic [DW-1:0] cache_data;
    logic [AW-1:0] vmem_addr;
    logic          vmem_write;
    logic [DW-1:0] vmem_data;
    logic          cache_stall;
    logic          flush_done;

    logic [DW-1:0] mem [DEPTH];
    int            wr_cnt;
    int            passed;
    int            total;
    logic [AW-1:0] exp_q [$];

    cache_flush_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_req   (flush_req),
        .cache_addr  (cache_addr),
        .cache_write (cache_write),
        .cache_data  (cache_data),
        .vmem_addr   (vmem_addr),
        .vmem_write  (vmem_write),
        .vmem_data   (vmem_data),
        .cache_stall (cache_stall),
        .flush_done  (flush_done)
    );

    // Clock and behavioural valid-bit memory.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
    end

    always @(posedge clk) begin
        if (vmem_write) begin
            mem[vmem_addr] <= vmem_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cache_addr  = a;
        cache_write = 1'b1;
        cache_data  = d;
        cyc();
        cache_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_req = 1'b0; cache_addr = 3'd6; cache_write = 1'b0; cache_data = 8'h00;
        cyc(); cyc();
        rst = 1'b0;
        #1;
`ifdef CACHE_FLUSH_ON_RESET_EN
        total++; if (cache_stall !== 1'b1) $display("FAIL reset_stall got=%b exp=1", cache_stall); else passed++;
        total++; if (vmem_addr !== 3'd0) $display("FAIL reset_addr got=%0d exp=0", vmem_addr); else passed++;
`else
        total++; if (cache_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", cache_stall); else passed++;
        total++; if (flush_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", flush_done); else passed++;
        total++; if (vmem_addr !== 3'd6 || vmem_write !== 1'b0)
            $display("FAIL reset_passthru got addr=%0d wr=%b exp addr=6 wr=0", vmem_addr, vmem_write);
        else passed++;
        cyc(); #1;
        total++; if (cache_stall !== 1'b0 || flush_done !== 1'b0)
            $display("FAIL reset_hold got stall=%b done=%b exp 0/0", cache_stall, flush_done);
        else passed++;
`endif
    endtask

`ifdef CACHE_FLUSH_ON_RESET_EN
    task automatic test_flush_on_reset();
        int done_cnt;
        done_cnt = 0;
        wr_cnt = 0;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(AW'(i));
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            total++; if (vmem_addr !== e || vmem_write !== 1'b1 || cache_stall !== 1'b1)
                $display("FAIL por_sweep got addr=%0d wr=%b stall=%b exp addr=%0d wr=1 stall=1",
                         vmem_addr, vmem_write, cache_stall, e);
            else passed++;
            if (flush_done) done_cnt++;
            cyc();
        end
        if (flush_done) done_cnt++;
        total++; if (cache_stall !== 1'b1) $display("FAIL por_done_stall got=%b exp=1", cache_stall); else passed++;
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (flush_done) done_cnt++;
            cyc();
        end
        total++; if (done_cnt !== 1) $display("FAIL por_done_count got=%0d exp=1", done_cnt); else passed++;
        total++; if (cache_stall !== 1'b0) $display("FAIL por_idle_stall got=%b exp=0", cache_stall); else passed++;
        total++; if (wr_cnt !== DEPTH) $display("FAIL por_writes got=%0d exp=%0d", wr_cnt, DEPTH); else passed++;
    endtask
`endif

    task automatic test_passthrough();
        cache_addr = 3'd5; cache_write = 1'b1; cache_data = 8'h01;
        #1;
        total++; if (vmem_addr !== 3'd5 || vmem_write !== 1'b1 || vmem_data !== 8'h01 || cache_stall !== 1'b0)
            $display("FAIL passthru got addr=%0d wr=%b data=%h stall=%b exp 5/1/01/0",
                     vmem_addr, vmem_write, vmem_data, cache_stall);
        else passed++;
        cyc();
        cache_write = 1'b0;
        #1;
        total++; if (mem[5] !== 8'h01) $display("FAIL passthru_mem got=%h exp=01", mem[5]); else passed++;
    endtask

    task automatic test_flush_pulse();
        int stall_cnt;
        stall_cnt = 0;
        for (int i = 0; i < DEPTH; i++) fill(AW'(i), 8'h80 | 8'(i));
        wr_cnt = 0;
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(AW'(i));
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            total++; if (vmem_addr !== e || vmem_write !== 1'b1 || vmem_data !== 8'h00 || flush_done !== 1'b0)
                $display("FAIL sweep_cycle got addr=%0d wr=%b data=%h done=%b exp addr=%0d wr=1 data=00 done=0",
                         vmem_addr, vmem_write, vmem_data, flush_done, e);
            else passed++;
            if (cache_stall) stall_cnt++;
            cyc();
        end
        total++; if (flush_done !== 1'b1 || vmem_write !== 1'b0)
            $display("FAIL sweep_done got done=%b wr=%b exp 1/0", flush_done, vmem_write);
        else passed++;
        if (cache_stall) stall_cnt++;
        cyc();
        if (cache_stall) stall_cnt++;
        total++; if (flush_done !== 1'b0) $display("FAIL sweep_done_pulse got=%b exp=0", flush_done); else passed++;
        total++; if (stall_cnt !== DEPTH + 1) $display("FAIL sweep_stall_cycles got=%0d exp=%0d", stall_cnt, DEPTH + 1); else passed++;
        total++; if (wr_cnt !== DEPTH) $display("FAIL sweep_writes got=%0d exp=%0d", wr_cnt, DEPTH); else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (mem[i] !== 8'h00) $display("FAIL sweep_mem[%0d] got=%h exp=00", i, mem[i]); else passed++;
        end
    endtask

    task automatic test_fill_with_flush();
        wr_cnt = 0;
        cache_addr = 3'd3; cache_write = 1'b1; cache_data = 8'hA5; flush_req = 1'b1;
        #1;
        total++; if (vmem_addr !== 3'd3 || vmem_write !== 1'b1 || vmem_data !== 8'hA5)
            $display("FAIL fill_flush_same got addr=%0d wr=%b data=%h exp 3/1/a5", vmem_addr, vmem_write, vmem_data);
        else passed++;
        cyc();
        cache_write = 1'b0; flush_req = 1'b0;
        #1;
        total++; if (mem[3] !== 8'hA5) $display("FAIL fill_flush_landed got=%h exp=a5", mem[3]); else passed++;
        for (int i = 0; i < DEPTH + 1; i++) cyc();
        total++; if (mem[3] !== 8'h00) $display("FAIL fill_flush_cleared got=%h exp=00", mem[3]); else passed++;
        total++; if (wr_cnt !== DEPTH + 1) $display("FAIL fill_flush_writes got=%0d exp=%0d", wr_cnt, DEPTH + 1); else passed++;
    endtask

    task automatic test_fill_during_flush();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        wr_cnt = 0;
        cache_addr = 3'd2; cache_write = 1'b1; cache_data = 8'hFF;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            total++; if (vmem_addr !== AW'(i) || vmem_data !== 8'h00)
                $display("FAIL drop_fill_cycle got addr=%0d data=%h exp addr=%0d data=00", vmem_addr, vmem_data, i);
            else passed++;
            cyc();
        end
        #1;
        total++; if (vmem_write !== 1'b0 || vmem_addr !== 3'd2)
            $display("FAIL drop_fill_done got wr=%b addr=%0d exp wr=0 addr=2", vmem_write, vmem_addr);
        else passed++;
        cyc();
        cache_write = 1'b0;
        total++; if (mem[2] !== 8'h00) $display("FAIL drop_fill_mem got=%h exp=00", mem[2]); else passed++;
        total++; if (wr_cnt !== DEPTH) $display("FAIL drop_fill_writes got=%0d exp=%0d", wr_cnt, DEPTH); else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < DEPTH; i++) fill(AW'(i), 8'h40 | 8'(i));
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        // Reset sampled at the edge that would advance idx to 4, so entry 4 is never written.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rst = 1'b1;
            cyc();
        end
        rst = 1'b0;
        cache_addr = 3'd7; cache_write = 1'b0;
        #1;
        total++; if (dut.state_q !== cache_pkg::IDLE)
            $display("FAIL rst_mid_state got=%0d exp=%0d", dut.state_q, cache_pkg::IDLE);
        else passed++;
        total++; if (cache_stall !== 1'b0 || flush_done !== 1'b0 || vmem_write !== 1'b0 || vmem_addr !== 3'd7)
            $display("FAIL rst_mid_outputs got stall=%b done=%b wr=%b addr=%0d exp 0/0/0/7",
                     cache_stall, flush_done, vmem_write, vmem_addr);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] e;
            e = (i < 4) ? 8'h00 : (8'h40 | 8'(i));
            total++; if (mem[i] !== e) $display("FAIL rst_mid_mem[%0d] got=%h exp=%h", i, mem[i], e); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        flush_req = 1'b1;
        cyc();
        for (int i = 0; i < DEPTH; i++) cyc();
        total++; if (flush_done !== 1'b1) $display("FAIL b2b_done got=%b exp=1", flush_done); else passed++;
        cyc();
        total++; if (cache_stall !== 1'b0 || dut.state_q !== cache_pkg::IDLE)
            $display("FAIL b2b_idle got stall=%b state=%0d exp 0/IDLE", cache_stall, dut.state_q);
        else passed++;
        cyc();
        flush_req = 1'b0;
        #1;
        total++; if (cache_stall !== 1'b1 || vmem_addr !== 3'd0 || vmem_write !== 1'b1)
            $display("FAIL b2b_restart got stall=%b addr=%0d wr=%b exp 1/0/1", cache_stall, vmem_addr, vmem_write);
        else passed++;
        for (int i = 0; i < DEPTH + 1; i++) cyc();
        total++; if (cache_stall !== 1'b0 || flush_done !== 1'b0)
            $display("FAIL b2b_end got stall=%b done=%b exp 0/0", cache_stall, flush_done);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        wr_cnt = 0;
        test_reset();
`ifdef CACHE_FLUSH_ON_RESET_EN
        test_flush_on_reset();
`endif
        test_passthrough();
        test_flush_pulse();
        test_fill_with_flush();
        test_fill_during_flush();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
